// File: rtl/bus_xfer_seq.sv
// Register-bank transfer sequencer: queues (src, dst) commands and moves each word over
// the shared OR-bus as a read cycle followed by a write cycle, driving one-hot oe/we strobes.
module bus_xfer_seq #(
    parameter int width  = 16,
    parameter int NREG   = 8,
    parameter int IDXW   = 3,
    parameter int QDEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [IDXW-1:0]   cmd_src_i,
    input  logic [IDXW-1:0]   cmd_dst_i,
    input  logic [width-1:0]  bus_in_i,
    output logic [NREG-1:0]   oe_o,
    output logic [NREG-1:0]   we_o,
    output logic [width-1:0]  last_data_o,
    output logic              busy_o,
    output logic [7:0]        xfer_cnt_o,
    output logic              err_o
);
    localparam int PTRW  = $clog2(QDEPTH);
    localparam int NSLOT = 2 ** IDXW;
    localparam logic [NSLOT-1:0] IDX_OK = NSLOT'((64'd1 << NREG) - 64'd1);

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
    typedef struct packed {
        logic [IDXW-1:0] src;
        logic [IDXW-1:0] dst;
    } cmd_t;

    cmd_t             mem_q [QDEPTH];
    logic [PTRW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PTRW:0]    count_q, count_d;
    state_t           state_q;
    cmd_t             cur_q;
    cmd_t             head;
    logic [NREG-1:0]  oe_q, we_q;
    logic [width-1:0] last_data_q;
    logic [7:0]       xfer_cnt_q;
    logic             err_q;
    logic             full, empty, accept, cmd_ok, push, pop;

    function automatic logic [NREG-1:0] onehot(input logic [IDXW-1:0] idx);
        return NREG'(1) << idx;
    endfunction

    assign full        = (count_q == (PTRW+1)'(QDEPTH));
    assign empty       = (count_q == '0);
    assign cmd_ready_o = !full;
    assign accept      = cmd_valid_i && !full;
    assign cmd_ok      = IDX_OK[cmd_src_i] && IDX_OK[cmd_dst_i];
    assign push        = accept && cmd_ok;
    // Only entries stored at an earlier edge are visible here, so a push never bypasses to the FSM.
    assign pop         = !empty && (state_q != READ);
    assign head        = mem_q[rd_ptr_q];
    assign count_d     = count_q + (PTRW+1)'(push) - (PTRW+1)'(pop);

    // NOTE: queue storage has no reset; the pointers and count alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= '{src: cmd_src_i, dst: cmd_dst_i};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTRW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTRW'(1);
            count_q <= count_d;
            if (accept && !cmd_ok) err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cur_q       <= '0;
            oe_q        <= '0;
            we_q        <= '0;
            last_data_q <= '0;
            xfer_cnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        state_q <= READ;
                        cur_q   <= head;
                        oe_q    <= onehot(head.src);
                    end
                end
                READ: begin
                    state_q <= WRITE;
                    we_q    <= onehot(cur_q.dst);
                end
                WRITE: begin
                    last_data_q <= bus_in_i;
                    xfer_cnt_q  <= xfer_cnt_q + 8'd1;
                    we_q        <= '0;
                    if (pop) begin
                        state_q <= READ;
                        cur_q   <= head;
                        oe_q    <= onehot(head.src);
                    end else begin
                        state_q <= IDLE;
                        oe_q    <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    oe_q    <= '0;
                    we_q    <= '0;
                end
            endcase
        end
    end

    assign oe_o        = oe_q;
    assign we_o        = we_q;
    assign last_data_o = last_data_q;
    assign xfer_cnt_o  = xfer_cnt_q;
    assign err_o       = err_q;
    assign busy_o      = (state_q != IDLE) || !empty;

endmodule

// File: tb/tb_bus_xfer_seq.sv
// Bench for bus_xfer_seq: a register bank on the OR-bus plus a timeline scoreboard that
// schedules each accepted command's pop/completion edge from the transfer timing rules.
module tb_bus_xfer_seq;
    localparam int W      = 16;
    localparam int NREG   = 6;
    localparam int IDXW   = 3;
    localparam int QDEPTH = 4;

    logic            clk, rst;
    logic            cmd_valid, cmd_ready;
    logic [IDXW-1:0] cmd_src, cmd_dst;
    logic [W-1:0]    bus_in;
    logic [NREG-1:0] oe, we;
    logic [W-1:0]    last_data;
    logic            busy, err;
    logic [7:0]      xfer_cnt;

    bus_xfer_seq #(.width(W), .NREG(NREG), .IDXW(IDXW), .QDEPTH(QDEPTH)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_src_i(cmd_src), .cmd_dst_i(cmd_dst),
        .bus_in_i(bus_in), .oe_o(oe), .we_o(we),
        .last_data_o(last_data), .busy_o(busy),
        .xfer_cnt_o(xfer_cnt), .err_o(err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Register bank: cleared while rst is high at an edge, preloadable, written by we strobes.
    logic [W-1:0] bank [NREG];
    logic         ld_en;
    int           ld_idx;
    logic [W-1:0] ld_val;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) bank[i] <= '0;
        end else begin
            if (ld_en) bank[ld_idx] <= ld_val;
            for (int i = 0; i < NREG; i++) if (we[i]) bank[i] <= bus_in;
        end
    end

    always_comb begin
        bus_in = '0;
        for (int i = 0; i < NREG; i++) if (oe[i]) bus_in = bus_in | bank[i];
    end

    // Scoreboard: every queued command gets its accept edge and pop edge; completion is pop+2.
    typedef struct {
        int src;
        int dst;
        int acc;
        int pop;
    } xfer_t;

    xfer_t        sched [$];
    int           edge_n, free_edge;
    logic [W-1:0] exp_regs [NREG];
    logic [W-1:0] exp_last;
    logic [7:0]   exp_cnt;
    logic         exp_err;
    int           n_checks, n_fail;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int model_count(input int e);
        int n = 0;
        foreach (sched[i]) if (sched[i].acc < e && sched[i].pop >= e) n++;
        return n;
    endfunction

    task automatic step(input bit v, input int s, input int d, output bit took);
        int              e, p;
        bit              rdy, x_busy;
        logic [NREG-1:0] x_oe, x_we;
        e   = edge_n + 1;
        rdy = (model_count(e) < QDEPTH);
        cmd_valid = v;
        cmd_src   = IDXW'(s);
        cmd_dst   = IDXW'(d);
        check("cmd_ready", cmd_ready, rdy);
        @(posedge clk);
        edge_n = e;
        took   = v && rdy;
        foreach (sched[i]) begin
            if (sched[i].pop + 2 == e) begin
                exp_last = exp_regs[sched[i].src];
                exp_regs[sched[i].dst] = exp_last;
                exp_cnt++;
            end
        end
        if (took) begin
            if (s < NREG && d < NREG) begin
                p = (e + 1 > free_edge) ? e + 1 : free_edge;
                sched.push_back('{s, d, e, p});
                free_edge = p + 2;
            end else begin
                exp_err = 1'b1;
            end
        end
        if (ld_en) exp_regs[ld_idx] = ld_val;
        while (sched.size() > 0 && sched[0].pop + 2 < e) void'(sched.pop_front());
        #1;
        x_oe = '0;
        x_we = '0;
        x_busy = 1'b0;
        foreach (sched[i]) begin
            if (sched[i].acc <= e && e < sched[i].pop + 2) x_busy = 1'b1;
            if (sched[i].pop <= e && e <= sched[i].pop + 1) x_oe = NREG'(1) << sched[i].src;
            if (sched[i].pop + 1 == e) x_we = NREG'(1) << sched[i].dst;
        end
        check("oe", oe, x_oe);
        check("we", we, x_we);
        check("busy", busy, x_busy);
        check("last_data", last_data, exp_last);
        check("xfer_cnt", xfer_cnt, exp_cnt);
        check("err", err, exp_err);
        for (int i = 0; i < NREG; i++) check($sformatf("bank%0d", i), bank[i], exp_regs[i]);
    endtask

    task automatic idle(input int n);
        bit t;
        repeat (n) step(1'b0, 0, 0, t);
    endtask

    task automatic send(input int s, input int d);
        bit took;
        int tries = 0;
        do begin
            step(1'b1, s, d, took);
            tries++;
        end while (!took && tries < 40);
        check("send_accepted", took, 1);
    endtask

    task automatic drain();
        int budget = 0;
        while (edge_n < free_edge && budget < 100) begin
            idle(1);
            budget++;
        end
        check("drained", edge_n >= free_edge, 1);
    endtask

    task automatic preload(input int idx, input logic [W-1:0] val);
        ld_en  = 1'b1;
        ld_idx = idx;
        ld_val = val;
        idle(1);
        ld_en  = 1'b0;
    endtask

    // Asynchronous pulse strictly between clock edges.
    task automatic do_reset();
        rst = 1'b1;
        #2;
        check("rst_oe", oe, 0);
        check("rst_we", we, 0);
        check("rst_cnt", xfer_cnt, 0);
        check("rst_last", last_data, 0);
        sched.delete();
        free_edge = 0;
        exp_cnt   = '0;
        exp_last  = '0;
        exp_err   = 1'b0;
        #1 rst = 1'b0;
        #1;
        check("rst_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
    endtask

    initial begin
        logic [W-1:0] saved;
        logic [7:0]   cnt_before;
        bit           t;
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_src = '0;
        cmd_dst = '0;
        ld_en = 1'b0;
        ld_idx = 0;
        ld_val = '0;
        edge_n = 0;
        free_edge = 0;
        n_checks = 0;
        n_fail = 0;
        exp_last = '0;
        exp_cnt = '0;
        exp_err = 1'b0;
        for (int i = 0; i < NREG; i++) exp_regs[i] = '0;

        repeat (2) @(posedge clk);
        #1;
        check("init_oe", oe, 0);
        check("init_we", we, 0);
        check("init_cnt", xfer_cnt, 0);
        check("init_err", err, 0);
        check("init_busy", busy, 0);
        rst = 1'b0;
        #1;
        check("init_ready", cmd_ready, 1);

        for (int i = 0; i < NREG; i++) preload(i, W'($urandom));

        // Single transfer 2 -> 5 with fixed expected timing.
        preload(2, 16'hA5A5);
        send(2, 5);
        idle(1);
        check("t2_oe_k1", oe, 6'h04);
        check("t2_we_k1", we, 6'h00);
        idle(1);
        check("t2_oe_k2", oe, 6'h04);
        check("t2_we_k2", we, 6'h20);
        idle(1);
        check("t2_r5", bank[5], 16'hA5A5);
        check("t2_last", last_data, 16'hA5A5);
        check("t2_cnt", xfer_cnt, 1);

        // Back-to-back chain: the value of R0 ripples to R4 in 8 cycles.
        do_reset();
        preload(0, 16'h1234);
        send(0, 1);
        send(1, 2);
        send(2, 3);
        send(3, 4);
        idle(5);
        check("t3_cnt_3", xfer_cnt, 3);
        idle(1);
        check("t3_cnt_4", xfer_cnt, 4);
        check("t3_r4", bank[4], 16'h1234);
        check("t3_busy", busy, 0);

        // Queue-full backpressure: consecutive offers outrun the 2-cycle transfer rate.
        for (int i = 0; i < 10; i++) send($urandom_range(NREG-1), $urandom_range(NREG-1));
        drain();

        // Out-of-range index: accepted, flagged, discarded.
        cnt_before = exp_cnt;
        send(7, 1);
        check("t5_err", err, 1);
        idle(3);
        check("t5_cnt", xfer_cnt, cnt_before);
        check("t5_oe", oe, 0);
        send(0, 1);
        drain();
        check("t5_cnt_next", xfer_cnt, cnt_before + 8'd1);

        // Random traffic with idle gaps and occasional bad indices.
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(9) == 0) send(NREG + $urandom_range(1), $urandom_range(NREG-1));
            else send($urandom_range(NREG-1), $urandom_range(NREG-1));
            idle($urandom_range(2));
        end
        drain();

        // Reset during WRITE: strobes drop immediately and the destination keeps its value.
        preload(1, ~exp_regs[4]);
        saved = exp_regs[4];
        send(1, 4);
        idle(2);
        check("t1_we_pre", we, 6'h10);
        do_reset();
        idle(1);
        check("t1_r4_kept", bank[4], saved);
        check("t1_cnt", xfer_cnt, 0);

        // Self-copy, then 255 more transfers: counter wraps back to zero.
        saved = exp_regs[3];
        send(3, 3);
        drain();
        check("t6_r3", bank[3], saved);
        for (int i = 0; i < 255; i++) send($urandom_range(NREG-1), $urandom_range(NREG-1));
        drain();
        check("t6_wrap", xfer_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
